// File: rtl/sd_resp_rx.sv
// sd_resp_rx: SD card command-response receiver.
// Arms on iStart, waits up to gTimeout strobes for a start bit on the CMD line,
// shifts in a 48-bit (R1/R3/R6/R7) or 136-bit (R2) frame, and checks the CRC7,
// transmission bit and end bit.
//
// Ports:
//   Clk, nResetAsync         system clock, asynchronous active-low reset
//   iStrobe, iCmd            per-SD-clock sample strobe and sampled CMD bit
//   iStart, iLong, iNoCrc    arm pulse, R2 frame select, skip CRC check
//   oBusy                    high whenever not idle
//   oDone, oTimeout          one-cycle completion / no-start-bit pulses
//   oCrcErr, oFrameErr       error flags, valid from oDone until next iStart
//   oIndex, oResp            parsed command index and payload
//
// state         | meaning
// ST_IDLE       | waiting for iStart
// ST_WAIT_START | armed, counting strobes until a start bit (0) appears
// ST_RECEIVE    | shifting frame bits, updating CRC7
// ST_CHECK      | one-cycle oDone pulse, then back to idle
module sd_resp_rx #(
    parameter int gTimeout   = 64,
    parameter int gRespWidth = 136
) (
    input  logic         Clk,
    input  logic         nResetAsync,
    input  logic         iStrobe,
    input  logic         iCmd,
    input  logic         iStart,
    input  logic         iLong,
    input  logic         iNoCrc,
    output logic         oBusy,
    output logic         oDone,
    output logic         oTimeout,
    output logic         oCrcErr,
    output logic         oFrameErr,
    output logic [5:0]   oIndex,
    output logic [127:0] oResp
);
    localparam int TmoW = $clog2(gTimeout + 1);
    localparam int BitW = $clog2(gRespWidth + 1);
    // The start bit is never stored, so the register only needs the bits
    // below the transmission bit; the incoming bit completes the frame.
    localparam int SW = gRespWidth - 2;
    localparam logic [BitW-1:0] ShortLen = BitW'(48);
    localparam logic [BitW-1:0] LongLen  = BitW'(gRespWidth);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_START,
        ST_RECEIVE,
        ST_CHECK
    } state_t;

    state_t            state_q, state_d;
    logic              long_q, long_d;
    logic              no_crc_q, no_crc_d;
    logic [TmoW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [SW-1:0]     shift_q, shift_d;
    logic [6:0]        crc_q, crc_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic              crc_err_q, crc_err_d;
    logic              frame_err_q, frame_err_d;
    logic [5:0]        index_q, index_d;
    logic [127:0]      resp_q, resp_d;

    logic [SW:0]       shift_nxt;
    logic [BitW-1:0]   frame_len;
    logic [TmoW-1:0]   tmo_inc;
    logic              trans_bit;

    // Serial CRC7, polynomial x^7 + x^3 + 1, MSB first.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
        logic fb;
        fb = crc[6] ^ bit_in;
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    always_comb begin
        state_d     = state_q;
        long_d      = long_q;
        no_crc_d    = no_crc_q;
        tmo_cnt_d   = tmo_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        crc_d       = crc_q;
        done_d      = 1'b0;
        timeout_d   = 1'b0;
        crc_err_d   = crc_err_q;
        frame_err_d = frame_err_q;
        index_d     = index_q;
        resp_d      = resp_q;

        // shift_nxt[k] is frame bit k once the end bit has arrived.
        shift_nxt = {shift_q, iCmd};
        frame_len = long_q ? LongLen : ShortLen;
        tmo_inc   = tmo_cnt_q + 1'b1;
        trans_bit = long_q ? shift_nxt[gRespWidth-2] : shift_nxt[46];

        case (state_q)
            ST_IDLE: begin
                if (iStart) begin
                    long_d      = iLong;
                    no_crc_d    = iNoCrc;
                    crc_err_d   = 1'b0;
                    frame_err_d = 1'b0;
                    index_d     = '0;
                    resp_d      = '0;
                    crc_d       = '0;
                    tmo_cnt_d   = '0;
                    bit_cnt_d   = '0;
                    shift_d     = '0;
                    state_d     = ST_WAIT_START;
                end
            end
            ST_WAIT_START: begin
                if (iStrobe) begin
                    if (!iCmd) begin
                        crc_d     = crc7_step(crc_q, 1'b0);
                        bit_cnt_d = BitW'(1);
                        state_d   = ST_RECEIVE;
                    end else begin
                        tmo_cnt_d = tmo_inc;
                        if (tmo_inc == TmoW'(gTimeout)) begin
                            timeout_d = 1'b1;
                            state_d   = ST_IDLE;
                        end
                    end
                end
            end
            ST_RECEIVE: begin
                if (iStrobe) begin
                    shift_d   = shift_nxt[SW-1:0];
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    // bit_cnt_q == 7 is frame bit 128: end of the R2 header,
                    // which is excluded from the R2 CRC.
                    if (long_q && bit_cnt_q == BitW'(7)) begin
                        crc_d = '0;
                    end else if (bit_cnt_q <= frame_len - BitW'(9)) begin
                        crc_d = crc7_step(crc_q, iCmd);
                    end
                    if (bit_cnt_q == frame_len - 1'b1) begin
                        done_d      = 1'b1;
                        crc_err_d   = (shift_nxt[7:1] != crc_q) && !no_crc_q;
                        frame_err_d = trans_bit || !shift_nxt[0];
                        if (long_q) begin
                            index_d = shift_nxt[gRespWidth-3 -: 6];
                            resp_d  = shift_nxt[127:0];
                        end else begin
                            index_d = shift_nxt[45:40];
                            resp_d  = {81'd0, shift_nxt[46:0]};
                        end
                        state_d = ST_CHECK;
                    end
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge nResetAsync) begin
        if (!nResetAsync) begin
            state_q     <= ST_IDLE;
            long_q      <= 1'b0;
            no_crc_q    <= 1'b0;
            tmo_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            crc_q       <= '0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            crc_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            index_q     <= '0;
            resp_q      <= '0;
        end else begin
            state_q     <= state_d;
            long_q      <= long_d;
            no_crc_q    <= no_crc_d;
            tmo_cnt_q   <= tmo_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            crc_q       <= crc_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            crc_err_q   <= crc_err_d;
            frame_err_q <= frame_err_d;
            index_q     <= index_d;
            resp_q      <= resp_d;
        end
    end

    assign oBusy     = (state_q != ST_IDLE);
    assign oDone     = done_q;
    assign oTimeout  = timeout_q;
    assign oCrcErr   = crc_err_q;
    assign oFrameErr = frame_err_q;
    assign oIndex    = index_q;
    assign oResp     = resp_q;

endmodule

// File: tb/tb_sd_resp_rx.sv
// tb_sd_resp_rx: scoreboard bench for sd_resp_rx. Expected results are
// derived from each transmitted frame by a polynomial-division CRC model and
// queued when the frame is sent; the monitor pops them on oDone/oTimeout.
module tb_sd_resp_rx;
    logic         Clk = 1'b0;
    logic         nResetAsync;
    logic         iStrobe, iCmd, iStart, iLong, iNoCrc;
    logic         oBusy, oDone, oTimeout, oCrcErr, oFrameErr;
    logic [5:0]   oIndex;
    logic [127:0] oResp;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit           is_tmo;
        bit           crc_err;
        bit           frame_err;
        logic [5:0]   index;
        logic [127:0] resp;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    sd_resp_rx #(.gTimeout(64), .gRespWidth(136)) dut (
        .Clk(Clk), .nResetAsync(nResetAsync), .iStrobe(iStrobe), .iCmd(iCmd),
        .iStart(iStart), .iLong(iLong), .iNoCrc(iNoCrc), .oBusy(oBusy),
        .oDone(oDone), .oTimeout(oTimeout), .oCrcErr(oCrcErr),
        .oFrameErr(oFrameErr), .oIndex(oIndex), .oResp(oResp)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // CRC7 as the remainder of frm[hi:lo] * x^7 divided by x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_div(input logic [135:0] frm, input int hi, input int lo);
        logic [7:0] rem;
        rem = 8'h00;
        for (int i = hi; i >= lo - 7; i--) begin
            rem = {rem[6:0], (i >= lo) ? frm[i] : 1'b0};
            if (rem[7]) rem = rem ^ 8'h89;
        end
        return rem[6:0];
    endfunction

    function automatic exp_t model(input logic [135:0] f, input bit lng, input bit nocrc);
        exp_t e;
        logic [6:0] c;
        e.is_tmo = 1'b0;
        if (lng) begin
            c           = crc7_div(f, 127, 8);
            e.frame_err = f[134] || !f[0];
            e.index     = f[133:128];
            e.resp      = f[127:0];
        end else begin
            c           = crc7_div(f, 47, 8);
            e.frame_err = f[46] || !f[0];
            e.index     = f[45:40];
            e.resp      = {80'd0, f[47:0]};
        end
        e.crc_err = (f[7:1] != c) && !nocrc;
        return e;
    endfunction

    function automatic logic [135:0] mk_short(input logic [5:0] idx, input logic [31:0] arg);
        logic [135:0] f;
        f        = '0;
        f[47:40] = {2'b00, idx};
        f[39:8]  = arg;
        f[7:1]   = crc7_div(f, 47, 8);
        f[0]     = 1'b1;
        return f;
    endfunction

    function automatic logic [135:0] mk_long(input logic [119:0] p);
        logic [135:0] f;
        f          = '0;
        f[135:128] = 8'h3F;
        f[127:8]   = p;
        f[7:1]     = crc7_div(f, 127, 8);
        f[0]       = 1'b1;
        return f;
    endfunction

    // All driver tasks start and end #1 after a rising edge.
    task automatic start(input bit lng, input bit nocrc);
        iStart = 1'b1; iLong = lng; iNoCrc = nocrc;
        @(posedge Clk); #1;
        iStart = 1'b0; iLong = 1'b0; iNoCrc = 1'b0;
    endtask

    task automatic strobe(input logic b, input int gap);
        repeat (gap) begin @(posedge Clk); #1; end
        iCmd = b; iStrobe = 1'b1;
        @(posedge Clk); #1;
        iStrobe = 1'b0; iCmd = 1'b1;
    endtask

    task automatic send_range(input logic [135:0] f, input int hi, input int lo, input int gap);
        for (int i = hi; i >= lo; i--) strobe(f[i], gap);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin @(posedge Clk); #1; n++; end
        chk({tag, "_pending"}, 128'(sb.size()), 128'd0);
        n = 0;
        while (oBusy && n < 50) begin @(posedge Clk); #1; n++; end
        chk({tag, "_idle"}, 128'(oBusy), 128'd0);
    endtask

    task automatic run_frame(input string tag, input logic [135:0] f, input bit lng,
                             input bit nocrc, input int pre, input int gap);
        sb.push_back(model(f, lng, nocrc));
        start(lng, nocrc);
        repeat (pre) strobe(1'b1, gap);
        send_range(f, lng ? 135 : 47, 0, gap);
        wait_drain(tag);
    endtask

    always @(negedge Clk) begin
        if (nResetAsync && (oDone || oTimeout)) begin
            chk("evt_expected", 128'(sb.size() != 0), 128'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                chk("evt_timeout", 128'(oTimeout), 128'(mon_e.is_tmo));
                chk("evt_done", 128'(oDone), 128'(!mon_e.is_tmo));
                if (!mon_e.is_tmo) begin
                    chk("crc_err", 128'(oCrcErr), 128'(mon_e.crc_err));
                    chk("frame_err", 128'(oFrameErr), 128'(mon_e.frame_err));
                    chk("index", 128'(oIndex), 128'(mon_e.index));
                    chk("resp", oResp, mon_e.resp);
                    chk("busy_at_done", 128'(oBusy), 128'd1);
                end
            end
        end
    end

    initial begin
        logic [135:0] f;
        logic [135:0] fl;
        exp_t         te;
        iStrobe = 1'b0; iCmd = 1'b1; iStart = 1'b0; iLong = 1'b0; iNoCrc = 1'b0;
        nResetAsync = 1'b1;
        #2 nResetAsync = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_busy", 128'(oBusy), 128'd0);
        chk("rst_flags", 128'({oDone, oTimeout, oCrcErr, oFrameErr}), 128'd0);
        chk("rst_index", 128'(oIndex), 128'd0);
        chk("rst_resp", oResp, 128'd0);
        nResetAsync = 1'b1;
        @(posedge Clk); #1;

        // Zero R1 with three idle-high strobes; check pulse width and busy drop.
        f = 136'h0000_0000_0001;
        sb.push_back(model(f, 1'b0, 1'b0));
        start(1'b0, 1'b0);
        repeat (3) strobe(1'b1, 1);
        send_range(f, 47, 0, 1);
        chk("r1_done_pulse", 128'(oDone), 128'd1);
        chk("r1_busy_in_check", 128'(oBusy), 128'd1);
        @(posedge Clk); #1;
        chk("r1_done_once", 128'(oDone), 128'd0);
        chk("r1_busy_low", 128'(oBusy), 128'd0);
        wait_drain("r1_zero");

        run_frame("crc_bad", 136'h0000_0000_0003, 1'b0, 1'b0, 0, 1);
        run_frame("crc_skip", 136'h0000_0000_0003, 1'b0, 1'b1, 0, 1);
        run_frame("trans_bit", 136'h4000_0000_0001, 1'b0, 1'b0, 2, 1);
        run_frame("end_bit", 136'h0000_0000_0000, 1'b0, 1'b0, 0, 1);

        for (int k = 0; k < 3; k++) begin
            f = mk_short(6'($urandom_range(0, 63)), $urandom);
            run_frame("r1_rand", f, 1'b0, 1'b0, k, 0);
        end

        // Timeout after exactly 64 high strobes.
        te = '{is_tmo: 1'b1, crc_err: 1'b0, frame_err: 1'b0, index: 6'd0, resp: 128'd0};
        sb.push_back(te);
        start(1'b0, 1'b0);
        repeat (63) strobe(1'b1, 1);
        chk("tmo_not_early", 128'({oBusy, oTimeout}), 128'b10);
        strobe(1'b1, 1);
        chk("tmo_pulse", 128'(oTimeout), 128'd1);
        chk("tmo_to_idle", 128'(oBusy), 128'd0);
        wait_drain("tmo");

        // Start bit on the 64th strobe is still a start bit.
        f = mk_short(6'h11, 32'hCAFE_0001);
        run_frame("start_at_64", f, 1'b0, 1'b0, 63, 1);

        // R2 frames: good CRC, then payload bit 64 flipped.
        fl = mk_long(120'({$urandom, $urandom, $urandom, $urandom}));
        run_frame("r2_good", fl, 1'b1, 1'b0, 1, 1);
        fl[64] = ~fl[64];
        run_frame("r2_flip", fl, 1'b1, 1'b0, 0, 0);

        // Reset in the middle of Receive aborts silently.
        f = mk_short(6'h2A, 32'h1234_5678);
        start(1'b0, 1'b0);
        send_range(f, 47, 28, 1);
        nResetAsync = 1'b0;
        #1;
        chk("mid_rst_busy", 128'(oBusy), 128'd0);
        chk("mid_rst_flags", 128'({oDone, oTimeout, oCrcErr, oFrameErr}), 128'd0);
        chk("mid_rst_resp", oResp, 128'd0);
        @(posedge Clk); #1;
        nResetAsync = 1'b1;
        @(posedge Clk); #1;
        run_frame("after_rst", f, 1'b0, 1'b0, 1, 1);

        // iStart (with iLong) mid-frame must not restart or change frame length.
        f = mk_short(6'h05, 32'h8000_00FF);
        sb.push_back(model(f, 1'b0, 1'b0));
        start(1'b0, 1'b0);
        send_range(f, 47, 38, 1);
        start(1'b1, 1'b1);
        send_range(f, 37, 0, 1);
        wait_drain("start_ignored");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sd_resp_rx.md
Name: sd_resp_rx

Overview:
- Receives SD card command responses on the serial CMD line and delivers parsed fields to the SD controller.
- Sits downstream of the CMD-line tristate driver/sampler. It consumes the sampled Cmd bit plus a per-SD-clock strobe.
- Detects the start bit within a timeout window and shifts in a 48-bit (R1/R3/R6/R7) or 136-bit (R2) frame.
- Checks the CRC7, transmission bit and end bit.

Parameters:
- gTimeout, 64, max strobes to wait for a start bit after arming (NCR limit).
- gRespWidth, 136, maximum frame length in bits.

Ports:
- Clk  in  1  system clock.
- nResetAsync  in  1  asynchronous active-low reset.
- iStrobe  in  1  one-Clk pulse marking the SD clock sampling point. A bit is consumed only when this is high.
- iCmd  in  1  sampled CMD line.
- iStart  in  1  arm the receiver (pulse). Honoured only in Idle.
- iLong  in  1  1 = 136-bit R2 frame, 0 = 48-bit. Latched with iStart.
- iNoCrc  in  1  1 = skip CRC check (R3). Latched with iStart.
- oBusy  out  1  high whenever not Idle.
- oDone  out  1  one-Clk pulse when a frame has been received.
- oTimeout  out  1  one-Clk pulse when no start bit arrives within gTimeout strobes.
- oCrcErr  out  1  CRC mismatch. Valid from oDone, held until next iStart.
- oFrameErr  out  1  transmission bit ≠ 0 or end bit ≠ 1. Same validity as oCrcErr.
- oIndex  out  6  command index field.
- oResp  out  128  response payload, defined below.

Behaviour:
- Reset: all outputs 0, state Idle, counters and CRC register 0. Reset asserted mid-frame aborts the frame with no oDone and no oTimeout.
- States: Idle, WaitStart, Receive, Check.
- Idle:
  - On iStart: latch iLong/iNoCrc; clear oCrcErr, oFrameErr, oIndex, oResp, CRC register, timeout counter; go to WaitStart next cycle.
- WaitStart, on each iStrobe:
  - iCmd=0: start bit. Feed 0 into the CRC, bit counter=1, go to Receive.
  - Otherwise: timeout counter +1. If the counter reaches gTimeout, pulse oTimeout and go to Idle.
  - The start bit arriving on the gTimeout-th strobe counts as a start bit, not a timeout.
- Receive, on each iStrobe:
  - Shift iCmd into the shift register MSB-first; bit counter +1.
  - CRC7: polynomial x^7+x^3+1, initial value 0, one bit per strobe, MSB-first.
  - Short frame: CRC covers frame bits 47..8 (start, trans, index, arg = 40 bits). Bits 7..1 are compared against the CRC.
  - Long frame: CRC covers frame bits 127..8 (120 bits). The CRC register is reset after bit 128 is shifted. Bits 7..1 are compared.
  - After bit 0 (end bit) is shifted (48 or 136 bits total), go to Check.
- Check (one cycle):
  - Pulse oDone.
  - oCrcErr = (received CRC ≠ computed CRC) AND NOT iNoCrc.
  - oFrameErr = (trans bit ≠ 0) OR (end bit ≠ 1).
  - Short frame: oIndex = frame[45:40], oResp[47:0] = frame[47:0], oResp[127:48] = 0.
  - Long frame: oIndex = frame[133:128] (expected 6'b111111), oResp = frame[127:0].
  - Go to Idle.
- Outputs hold their values until the next accepted iStart.
- iStart outside Idle is ignored.
- iStrobe is ignored in Idle and Check.
- Latency: oDone is asserted one Clk after the Clk that consumed the end-bit strobe.
- iStrobe asserted on consecutive Clk cycles is legal; every strobe consumes one bit.

Test Plan:
- Zero R1: iStart, iLong=0, iNoCrc=0, then 3 idle-high strobes and frame 48'h0000_0000_0001 → oDone once, oCrcErr=0, oFrameErr=0, oIndex=0, oResp=48'h1. oBusy low one cycle after oDone.
- CRC corruption: same frame but 48'h0000_0000_0003 (CRC field = 7'h01) → oDone, oCrcErr=1, oFrameErr=0. Repeat with iNoCrc=1 → oCrcErr=0.
- Framing: 48'h4000_0000_0001 (trans=1) → oFrameErr=1. 48'h0000_0000_0000 (end bit 0) → oFrameErr=1.
- Timeout: iStart, CMD held high for 64 strobes → oTimeout pulse on strobe 64, no oDone, back to Idle. Start bit on strobe 64 instead → frame received, no oTimeout.
- R2: iLong=1, 136-bit frame with header 8'h3F, payload from the bench CRC model with correct CRC → oDone, oCrcErr=0, oIndex=6'h3F, oResp equals frame[127:0]. Flip payload bit 64 → oCrcErr=1.
- Reset and robustness:
  - nResetAsync asserted mid-Receive → all outputs 0 immediately, Idle.
  - A subsequent clean frame is received correctly.
  - iStart pulsed during Receive has no effect.
